// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : RV32I instruction encoder. Packs decoded fields (opcode, rd,
//             rs1, rs2, funct3, funct7, sign-extended immediate) into a 32-bit
//             instruction word. Illegal field sets are rejected with an error
//             code; legal words leave through a registered valid/ready stage,
//             tagged with an auto-incrementing byte address.
//  Ports    : clk, rst_n            clock, synchronous active-low reset
//             in_valid/in_ready     field-set handshake
//             in_opcode..in_imm     decoded instruction fields
//             base_load/base_addr   reload of the address counter
//             out_valid/out_ready   encoded-word handshake
//             out_instr/out_addr    encoded word and its byte address
//             err/err_code          illegal-input pulse and held reason code
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int          ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [2:0]        err_code
);

    localparam logic [ADDR_W-1:0] c_word_mask = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_base      = ADDR_W'(BASE_ADDR) & c_word_mask;

    localparam logic [6:0] c_op_imm = 7'b0010011;
    localparam logic [6:0] c_jalr   = 7'b1100111;
    localparam logic [6:0] c_load   = 7'b0000011;
    localparam logic [6:0] c_lui    = 7'b0110111;
    localparam logic [6:0] c_auipc  = 7'b0010111;
    localparam logic [6:0] c_jal    = 7'b1101111;
    localparam logic [6:0] c_store  = 7'b0100011;
    localparam logic [6:0] c_branch = 7'b1100011;
    localparam logic [6:0] c_op     = 7'b0110011;

    localparam logic [2:0] c_ok        = 3'd0;
    localparam logic [2:0] c_bad_op    = 3'd1;
    localparam logic [2:0] c_bad_f3    = 3'd2;
    localparam logic [2:0] c_bad_f7    = 3'd3;
    localparam logic [2:0] c_bad_range = 3'd4;
    localparam logic [2:0] c_bad_align = 3'd5;

    localparam logic [6:0] c_f7_alt = 7'b0100000;

    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_pc;
    logic              r_err;
    logic [2:0]        r_err_code;

    logic              w_accept;
    logic [ADDR_W-1:0] w_eff_pc;
    logic [2:0]        w_code;
    logic [31:0]       w_instr;
    logic [31:0]       w_i_word;

    // A value fits in n signed bits when bits [31:n-1] are all equal.
    function automatic logic fits_signed(input logic [31:0] v, input int n);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << (n - 1);
        return ((v & m) == 32'd0) || ((v & m) == m);
    endfunction

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // A same-cycle base_load redirects the word being accepted as well.
    assign w_eff_pc = base_load ? (base_addr & c_word_mask) : r_pc;

    assign w_i_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};

    // Checks inside each branch are ordered opcode > funct3 > funct7 >
    // range > alignment so the first failing rule wins.
    always_comb begin
        w_code  = c_ok;
        w_instr = 32'd0;
        case (in_opcode)
            c_op_imm: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
                    if (!(in_funct7 == 7'd0 ||
                          (in_funct3 == 3'b101 && in_funct7 == c_f7_alt)))
                        w_code = c_bad_f7;
                    else if (in_imm[31:5] != 27'd0)
                        w_code = c_bad_range;
                    w_instr = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                end else begin
                    if (!fits_signed(in_imm, 12))
                        w_code = c_bad_range;
                    w_instr = w_i_word;
                end
            end
            c_jalr, c_load: begin
                if ((in_opcode == c_jalr && in_funct3 != 3'b000) ||
                    (in_opcode == c_load &&
                     (in_funct3 == 3'b011 || in_funct3 == 3'b110 || in_funct3 == 3'b111)))
                    w_code = c_bad_f3;
                else if (!fits_signed(in_imm, 12))
                    w_code = c_bad_range;
                w_instr = w_i_word;
            end
            c_lui, c_auipc: begin
                if (in_imm[11:0] != 12'd0)
                    w_code = c_bad_align;
                w_instr = {in_imm[31:12], in_rd, in_opcode};
            end
            c_jal: begin
                if (!fits_signed(in_imm, 21))
                    w_code = c_bad_range;
                else if (in_imm[0])
                    w_code = c_bad_align;
                w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            end
            c_store: begin
                if (in_funct3 > 3'b010)
                    w_code = c_bad_f3;
                else if (!fits_signed(in_imm, 12))
                    w_code = c_bad_range;
                w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            end
            c_branch: begin
                if (in_funct3 == 3'b010 || in_funct3 == 3'b011)
                    w_code = c_bad_f3;
                else if (!fits_signed(in_imm, 13))
                    w_code = c_bad_range;
                else if (in_imm[0])
                    w_code = c_bad_align;
                w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
            end
            c_op: begin
                if (!(in_funct7 == 7'd0 ||
                      (in_funct7 == c_f7_alt && (in_funct3 == 3'b000 || in_funct3 == 3'b101))))
                    w_code = c_bad_f7;
                w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            default: w_code = c_bad_op;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_addr  <= c_base;
            r_pc        <= c_base;
            r_err       <= 1'b0;
            r_err_code  <= c_ok;
        end else if (w_accept && w_code == c_ok) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_instr;
            r_out_addr  <= w_eff_pc;
            r_pc        <= w_eff_pc + ADDR_W'(4);
            r_err       <= 1'b0;
            r_err_code  <= c_ok;
        end else begin
            // An illegal accept implies in_ready, so any held word is being
            // consumed this cycle; dropping valid on out_ready covers both.
            if (out_ready)
                r_out_valid <= 1'b0;
            r_pc  <= w_eff_pc;
            r_err <= w_accept;
            if (w_accept)
                r_err_code <= w_code;
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Self-checking bench for instr_encoder. Directed vectors with
//             known instruction words, illegal-field cases, backpressure,
//             base reload, address wrap and reset mid-transfer, followed by
//             randomized legal/illegal traffic. Emitted words are decoded
//             back into fields and compared with what was sent.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int          ADDR_W = 12;
    localparam int unsigned BASE   = 0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [2:0]        err_code;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .base_load(base_load), .base_addr(base_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fld_t;

    typedef struct {
        fld_t              f;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       gold;
        bit                has_gold;
    } exp_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Keep only the fields that the instruction format actually carries.
    function automatic fld_t canon(input fld_t f);
        fld_t c;
        c    = '0;
        c.op = f.op;
        case (f.op)
            7'h13: begin
                c.rd = f.rd; c.rs1 = f.rs1; c.f3 = f.f3; c.imm = f.imm;
                if (f.f3 == 3'd1 || f.f3 == 3'd5) c.f7 = f.f7;
            end
            7'h67, 7'h03: begin c.rd = f.rd; c.rs1 = f.rs1; c.f3 = f.f3; c.imm = f.imm; end
            7'h37, 7'h17, 7'h6F: begin c.rd = f.rd; c.imm = f.imm; end
            7'h23, 7'h63: begin c.rs1 = f.rs1; c.rs2 = f.rs2; c.f3 = f.f3; c.imm = f.imm; end
            7'h33: begin c.rd = f.rd; c.rs1 = f.rs1; c.rs2 = f.rs2; c.f3 = f.f3; c.f7 = f.f7; end
            default: ;
        endcase
        return c;
    endfunction

    // Reference decoder: recover fields and imm_ext from a word.
    function automatic fld_t decode(input logic [31:0] i);
        fld_t d;
        d     = '0;
        d.op  = i[6:0];
        d.rd  = i[11:7];
        d.f3  = i[14:12];
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.f7  = i[31:25];
        case (d.op)
            7'h13: begin
                if (d.f3 == 3'd1 || d.f3 == 3'd5) d.imm = {27'd0, i[24:20]};
                else d.imm = {{20{i[31]}}, i[31:20]};
            end
            7'h67, 7'h03: d.imm = {{20{i[31]}}, i[31:20]};
            7'h23: d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63: d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'h37, 7'h17: d.imm = {i[31:12], 12'd0};
            7'h6F: d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: ;
        endcase
        return canon(d);
    endfunction

    function automatic fld_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm);
        fld_t f;
        f.op = op; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2; f.f3 = f3; f.f7 = f7; f.imm = imm;
        return f;
    endfunction

    // ---------------------------------------------------------------- model
    exp_t              q[$];
    logic [ADDR_W-1:0] m_pc        = ADDR_W'(BASE);
    bit                m_err       = 1'b0;
    logic [2:0]        m_code      = 3'd0;
    bit                m_after_rst = 1'b1;
    bit                hold_prev   = 1'b0;
    logic [31:0]       hold_instr;
    logic [ADDR_W-1:0] hold_addr;
    bit                mon_on      = 1'b0;
    int                cur_code    = 0;
    logic [31:0]       cur_gold    = 32'd0;
    bit                cur_hg      = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            logic [ADDR_W-1:0] eff;
            fld_t              cf;
            check("in_ready", in_ready, (q.size() == 0) || out_ready);
            check("out_valid", out_valid, q.size() != 0);
            check("err", err, m_err);
            check("err_code", err_code, m_code);
            if (m_after_rst) begin
                check("rst_addr", out_addr, BASE & ~32'd3);
                check("rst_instr", out_instr, 0);
            end
            if (hold_prev && out_valid) begin
                check("hold_instr", out_instr, hold_instr);
                check("hold_addr", out_addr, hold_addr);
            end
            if (out_valid && q.size() != 0) begin
                check("fields", decode(out_instr), canon(q[0].f));
                check("addr", out_addr, q[0].addr);
                if (q[0].has_gold) check("word", out_instr, q[0].gold);
            end
            hold_prev  = out_valid && !out_ready;
            hold_instr = out_instr;
            hold_addr  = out_addr;
            if (!rst_n) begin
                q.delete();
                m_pc        = ADDR_W'(BASE) & ~ADDR_W'(3);
                m_err       = 1'b0;
                m_code      = 3'd0;
                m_after_rst = 1'b1;
                hold_prev   = 1'b0;
            end else begin
                m_after_rst = 1'b0;
                eff = base_load ? (base_addr & ~ADDR_W'(3)) : m_pc;
                if (out_ready && q.size() != 0) void'(q.pop_front());
                if (in_valid && in_ready) begin
                    if (cur_code == 0) begin
                        cf = mk(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
                        q.push_back('{f: cf, addr: eff, gold: cur_gold, has_gold: cur_hg});
                        m_pc   = eff + ADDR_W'(4);
                        m_err  = 1'b0;
                        m_code = 3'd0;
                    end else begin
                        m_pc   = eff;
                        m_err  = 1'b1;
                        m_code = cur_code[2:0];
                    end
                end else begin
                    m_pc  = eff;
                    m_err = 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------- driver
    bit rand_rdy = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    task automatic present(input fld_t f, input int code, input logic [31:0] gold, input bit hg);
        in_opcode = f.op; in_rd = f.rd; in_rs1 = f.rs1; in_rs2 = f.rs2;
        in_funct3 = f.f3; in_funct7 = f.f7; in_imm = f.imm;
        cur_code = code; cur_gold = gold; cur_hg = hg;
        in_valid = 1'b1;
    endtask

    task automatic send(input fld_t f, input int code, input logic [31:0] gold, input bit hg);
        bit acc;
        acc = 1'b0;
        present(f, code, gold, hg);
        for (int n = 0; n < 100; n++) begin
            acc = in_ready;
            tick();
            if (acc) break;
        end
        if (!acc) check("send_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rimm(input int bits);
        return 32'($signed($urandom) >>> (32 - bits));
    endfunction

    function automatic fld_t gen_legal();
        fld_t        f;
        logic [2:0]  opimm_f3[6]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        logic [2:0]  load_f3[5]   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  branch_f3[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        f = {$urandom, $urandom};
        case ($urandom_range(0, 8))
            0: begin f.op = 7'h13; f.f3 = opimm_f3[$urandom_range(0, 5)]; f.imm = rimm(12); end
            1: begin
                f.op  = 7'h13;
                f.f3  = $urandom_range(0, 1) ? 3'd1 : 3'd5;
                f.f7  = (f.f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                f.imm = $urandom_range(0, 31);
            end
            2: begin f.op = 7'h67; f.f3 = 3'd0; f.imm = rimm(12); end
            3: begin f.op = 7'h03; f.f3 = load_f3[$urandom_range(0, 4)]; f.imm = rimm(12); end
            4: begin f.op = $urandom_range(0, 1) ? 7'h37 : 7'h17; f.imm = $urandom & 32'hFFFF_F000; end
            5: begin f.op = 7'h6F; f.imm = rimm(21) & ~32'd1; end
            6: begin f.op = 7'h23; f.f3 = 3'($urandom_range(0, 2)); f.imm = rimm(12); end
            7: begin f.op = 7'h63; f.f3 = branch_f3[$urandom_range(0, 5)]; f.imm = rimm(13) & ~32'd1; end
            default: begin
                f.op = 7'h33;
                f.f3 = 3'($urandom_range(0, 7));
                f.f7 = ((f.f3 == 3'd0 || f.f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
        endcase
        return f;
    endfunction

    function automatic bool_known(input logic [6:0] op);
        return op inside {7'h13, 7'h67, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h23, 7'h63, 7'h33};
    endfunction

    task automatic gen_illegal(output fld_t f, output int code);
        logic [2:0] bad_op_f3[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        f = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: begin
                f.op = 7'h7F;
                for (int k = 0; k < 20; k++) begin
                    logic [6:0] o;
                    o = 7'($urandom);
                    if (!bool_known(o)) begin f.op = o; break; end
                end
                code = 1;
            end
            1: begin f.op = 7'h03; f.f3 = $urandom_range(0, 1) ? 3'd3 : 3'd7; code = 2; end
            2: begin
                f.op = 7'h13; f.f3 = 3'd0;
                f.imm = 32'd2048 + $urandom_range(0, 100000);
                if ($urandom_range(0, 1) == 1) f.imm = -f.imm - 32'd1;
                code = 4;
            end
            3: begin f.op = 7'h63; f.f3 = 3'd1; f.imm = rimm(13) | 32'd1; code = 5; end
            4: begin f.op = 7'h33; f.f3 = bad_op_f3[$urandom_range(0, 4)]; f.f7 = 7'h20; code = 3; end
            default: begin f.op = 7'h23; f.f3 = 3'd2; f.imm = 32'h0001_0000; code = 4; end
        endcase
    endtask

    initial begin
        fld_t f;
        int   code;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; base_load = 1'b0; base_addr = '0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (2) tick();
        mon_on = 1'b1;
        tick();
        rst_n = 1'b1;

        send(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5), 0, 32'h0050_0093, 1);
        send(mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0), 0, 32'h4020_81B3, 1);
        repeat (2) tick();

        rst_n = 1'b0; tick(); rst_n = 1'b1;
        send(mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, -32'sd8), 0, 32'hFE20_8CE3, 1);
        send(mk(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, -32'sd4), 0, 32'hFE51_2E23, 1);
        send(mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h800), 0, 32'h0010_00EF, 1);

        send(mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3),    5, 32'd0, 0);
        send(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048), 4, 32'd0, 0);
        send(mk(7'h03, 5'd1, 5'd2, 5'd0, 3'd3, 7'h00, 32'd0),    2, 32'd0, 0);
        send(mk(7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 7'h20, 32'd3),    3, 32'd0, 0);
        send(mk(7'h7F, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'd0),    1, 32'd0, 0);
        tick();
        send(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5), 0, 32'h0050_0093, 1);
        repeat (2) tick();

        out_ready = 1'b0;
        send(mk(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7), 0, 32'h0070_0113, 1);
        present(mk(7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0), 0, 32'h0020_8233, 1);
        repeat (3) tick();
        out_ready = 1'b1;
        send(mk(7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0), 0, 32'h0020_8233, 1);
        tick();

        base_load = 1'b1; base_addr = ADDR_W'(12'h103);
        send(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5), 0, 32'h0050_0093, 1);
        base_load = 1'b0;
        send(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5), 0, 32'h0050_0093, 1);
        base_load = 1'b1; base_addr = ADDR_W'(12'hFFC);
        tick();
        base_load = 1'b0;
        send(gen_legal(), 0, 32'd0, 0);
        send(gen_legal(), 0, 32'd0, 0);
        tick();

        out_ready = 1'b0;
        send(gen_legal(), 0, 32'd0, 0);
        tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) tick();

        rand_rdy = 1'b1;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0) tick();
            if ($urandom_range(0, 19) == 0) begin
                base_load = 1'b1;
                base_addr = ADDR_W'($urandom);
            end
            if ($urandom_range(0, 4) == 0) begin
                gen_illegal(f, code);
                send(f, code, 32'd0, 0);
            end else begin
                send(gen_legal(), 0, 32'd0, 0);
            end
            base_load = 1'b0;
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
RV32I instruction encoder. The inverse of the team's field decoder: it accepts decoded fields (opcode, registers, funct3/funct7, sign-extended immediate) and packs them into a 32-bit instruction word. Illegal field combinations are rejected with an error code. Legal words are emitted through a registered valid/ready stage, tagged with an auto-incrementing byte address so they can be written straight into instruction memory (program loader / test-program generator path).

Parameters:
ADDR_W, 12, width of the output byte address; wraps modulo 2^ADDR_W.
BASE_ADDR, 0, address counter value after reset; bits [1:0] forced to 0.

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous reset, active-low.
in_valid  in  1  field set valid.
in_ready  out  1  encoder can accept this cycle.
in_opcode  in  7  instruction opcode.
in_rd  in  5  destination register.
in_rs1  in  5  source register 1.
in_rs2  in  5  source register 2.
in_funct3  in  3  funct3.
in_funct7  in  7  funct7.
in_imm  in  32  immediate, sign-extended value (same convention as decoder imm_ext; shamt for SLLI/SRLI/SRAI).
base_load  in  1  load address counter from base_addr.
base_addr  in  ADDR_W  new base address; bits [1:0] ignored.
out_valid  out  1  encoded word valid.
out_ready  in  1  consumer accepts word.
out_instr  out  32  encoded instruction.
out_addr  out  ADDR_W  byte address of out_instr.
err  out  1  one-cycle pulse: last accepted field set was illegal.
err_code  out  3  0 ok, 1 bad opcode, 2 bad funct3, 3 bad funct7, 4 imm out of range, 5 imm misaligned.

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_instr=0, out_addr=BASE_ADDR, internal pc=BASE_ADDR, err=0, err_code=0. Reset mid-transfer discards the held word.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Legal accept: next cycle out_valid=1, out_instr=encoding, out_addr=pc, pc<=pc+4 (wraps). Latency 1 cycle. err=0, err_code=0.
- Illegal accept: nothing emitted, pc unchanged, err=1 for one cycle, err_code set. out_valid<=0 if the held word was consumed in the same cycle, otherwise held. err_code holds until the next accept.
- Output hold: while out_valid && !out_ready, out_instr/out_addr stay stable and in_ready=0.
- No accept while out_valid && out_ready: out_valid<=0.
- base_load: pc<=base_addr&~3. If accept occurs in the same cycle, the accepted legal word takes base_addr and pc<=base_addr+4.
- Error priority: opcode > funct3 > funct7 > range > alignment.
- Signed range of N bits: in_imm[31:N-1] all equal.
- Encoding and legality by opcode:
  - 0010011 OP-IMM, funct3 000/010/011/100/110/111: imm 12-bit signed -> {imm[11:0],rs1,f3,rd,op}.
  - OP-IMM, funct3 001: funct7 must be 0000000. funct3 101: funct7 must be 0000000 or 0100000. shamt in_imm must be 0..31, else code 4. Encoding {funct7,imm[4:0],rs1,f3,rd,op}.
  - 1100111 JALR: funct3 must be 000. imm 12-bit signed; same layout as OP-IMM.
  - 0000011 LOAD: funct3 in {000,001,010,100,101}. imm 12-bit signed.
  - 0110111 LUI / 0010111 AUIPC: imm[11:0] must be 0 (code 5). Encoding {imm[31:12],rd,op}. funct3/funct7 ignored.
  - 1101111 JAL: imm 21-bit signed (code 4). imm[0]=0 (code 5). Encoding {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
  - 0100011 STORE: funct3 in {000,001,010}. imm 12-bit signed. Encoding {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - 1100011 BRANCH: funct3 not 010/011. imm 13-bit signed. imm[0]=0. Encoding {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - 0110011 OP: any funct3. funct7 0000000, or 0100000 only for funct3 000/101. Encoding {funct7,rs2,rs1,f3,rd,op}. imm ignored.
  - Any other opcode: code 1.
- Fields not used by the format are ignored, never checked.

Test Plan:
- After reset: ADDI x1,x0,5 (op 13,f3 0,rd 1,imm 5) -> next cycle out_instr=0x00500093, out_addr=0. Then SUB x3,x1,x2 (funct7 0x20) -> 0x402081B3, out_addr=4.
- BEQ x1,x2,imm=-8 -> 0xFE208CE3. SW x5,-4(x2) -> 0xFE512E23. JAL x1,imm=0x800 -> 0x001000EF. Addresses 0,4,8.
- Illegal: BEQ imm=3 -> err pulse, code 5. ADDI imm=2048 -> code 4. LOAD f3=011 -> code 2. SLLI funct7=0x20 -> code 3. Opcode 0x7F -> code 1. No out_valid, pc unchanged.
- Backpressure: out_ready=0, two back-to-back legal inputs -> first word held stable, in_ready=0, second accepted the cycle out_ready rises, addresses consecutive.
- base_load=1, base_addr=0x103, concurrent ADDI accept -> out_addr=0x100, next word 0x104. pc at 0xFFC with ADDR_W=12 -> next word wraps to 0x000.
- Assert rst_n=0 while out_valid && !out_ready -> out_valid=0, out_addr=BASE_ADDR next cycle.
- Round-trip: random legal field sets through encoder then decoder -> decoded fields and imm_ext match inputs.
